// File: rtl/boot_pkg.sv
// ============================================================================
// boot_pkg : shared state codes, write-size encodings and default constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_CHECK   = 3'd2;
  localparam state_t ST_RELEASE = 3'd3;
  localparam state_t ST_RUN     = 3'd4;
  localparam state_t ST_ERROR   = 3'd5;

  localparam logic [1:0] WS_BYTE = 2'd0;
  localparam logic [1:0] WS_HALF = 2'd1;
  localparam logic [1:0] WS_WORD = 2'd2;

  localparam logic [31:0] DEFAULT_START_ADDR = 32'h8000_0000;
  localparam int          DEFAULT_MEM_SIZE   = 8192;

endpackage

`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
// ============================================================================
// boot_loader_ctrl : streams a program image into memory with read-back
//                    verify, then hands the memory port to the CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
  parameter int          MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int          RESET_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_write_size,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        sel_cpu,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        truncated,
  output logic [31:0] byte_count,
  output logic [31:0] error_addr
);

  localparam logic [31:0] MEM_LAST  = 32'(MEM_SIZE - 1);
  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lat_byte;
  logic        lat_last;
  logic [31:0] hold_cnt;
  logic        rd_mismatch;
  logic        count_full;
  logic        unused_rd;

  assign rd_mismatch = (mem_rd[7:0] != lat_byte);
  assign count_full  = (byte_count == MEM_LAST);
  assign unused_rd   = ^mem_rd[31:8];

  // byte_ready is a registered decode of LOAD, so gating with it keeps
  // the write strobe free of state-decode glitches.
  assign mem_we         = byte_ready & byte_valid;
  assign mem_wd         = byte_ready ? {24'h0, byte_data} : 32'h0;
  assign mem_write_size = WS_BYTE;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LOAD;
      ST_LOAD:    if (byte_valid) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (rd_mismatch)                  state_nxt = ST_ERROR;
        else if (lat_last || count_full)  state_nxt = ST_RELEASE;
        else                              state_nxt = ST_LOAD;
      end
      ST_RELEASE: if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
      ST_RUN:     state_nxt = ST_RUN;
      ST_ERROR:   state_nxt = ST_ERROR;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      sel_cpu    <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      truncated  <= 1'b0;
      byte_count <= 32'h0;
      mem_addr   <= START_ADDR;
      error_addr <= 32'h0;
      lat_byte   <= 8'h0;
      lat_last   <= 1'b0;
      hold_cnt   <= 32'h0;
    end else begin
      state      <= state_nxt;
      // Status flags are registered from the next state to stay glitch-free.
      byte_ready <= (state_nxt == ST_LOAD);
      busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK) ||
                    (state_nxt == ST_RELEASE);
      sel_cpu    <= (state_nxt == ST_RELEASE) || (state_nxt == ST_RUN);
      cpu_reset  <= (state_nxt != ST_RUN);
      done       <= (state_nxt == ST_RUN);
      error      <= (state_nxt == ST_ERROR);
      hold_cnt   <= (state == ST_RELEASE) ? hold_cnt + 32'd1 : 32'h0;

      if (state == ST_IDLE && start) begin
        byte_count <= 32'h0;
        mem_addr   <= START_ADDR;
        truncated  <= 1'b0;
      end

      if (state == ST_LOAD && byte_valid) begin
        lat_byte <= byte_data;
        lat_last <= byte_last;
      end

      if (state == ST_CHECK) begin
        if (rd_mismatch) begin
          error_addr <= mem_addr;
        end else begin
          byte_count <= byte_count + 32'd1;
          mem_addr   <= mem_addr + 32'd1;
          if (!lat_last && count_full) truncated <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
// ============================================================================
// tb_boot_loader_ctrl : directed self-checking bench for boot_loader_ctrl
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_boot_loader_ctrl;

  localparam int          HOLD  = 3;
  localparam int          MSIZE = 8192;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        byte_last = 1'b0;
  logic        byte_ready, mem_we, sel_cpu, cpu_reset, busy, done, error, truncated;
  logic [1:0]  mem_write_size;
  logic [31:0] mem_addr, mem_wd, mem_rd, byte_count, error_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int oob = 0;
  int bad_wr = 0;

  logic [7:0]  mem   [0:MSIZE-1];
  logic [7:0]  sdata [0:8199];
  logic        force_en = 1'b0;
  logic [12:0] force_idx = 13'd0;
  logic [31:0] wr_off;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign wr_off = mem_addr - BASE;
  assign mem_rd = (force_en && mem_addr[12:0] == force_idx) ? 32'h0 : {24'h0, mem[mem_addr[12:0]]};

  always @(posedge clk) begin
    if (mem_we) begin
      wr_count = wr_count + 1;
      if (wr_off >= 32'(MSIZE)) oob = oob + 1;
      else mem[wr_off[12:0]] = mem_wd[7:0];
      if (mem_write_size != 2'd0 || mem_wd[31:8] != 24'h0) bad_wr = bad_wr + 1;
    end
  end

  boot_loader_ctrl #(
    .START_ADDR (BASE),
    .MEM_SIZE   (MSIZE),
    .RESET_HOLD (HOLD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_last      (byte_last),
    .byte_ready     (byte_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_size (mem_write_size),
    .mem_wd         (mem_wd),
    .mem_rd         (mem_rd),
    .sel_cpu        (sel_cpu),
    .cpu_reset      (cpu_reset),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .truncated      (truncated),
    .byte_count     (byte_count),
    .error_addr     (error_addr)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives a byte stream (start pulsed on the first cycle); returns on a negedge.
  task automatic run_stream(input int n, input bit use_last, input int gap_at, input int gap_len,
                            input int pulse_at, input int budget,
                            output int got, output int start_cyc, output int gap_we, output int gap_idle);
    int i; int c; int g;
    i = 0; c = 0; g = 0; gap_we = 0; gap_idle = 0; start_cyc = 0;
    while (i < n && c < budget) begin
      @(negedge clk);
      c++;
      start = (c == 1) || (c == pulse_at);
      if (c == 1) start_cyc = cyc;
      if (i == gap_at && g < gap_len) begin
        byte_valid = 1'b0;
        g++;
        #1;
        if (mem_we) gap_we++;
        if (g > 1 && !byte_ready) gap_idle++;
      end else begin
        byte_valid = 1'b1;
        byte_data  = sdata[i];
        byte_last  = use_last && (i == n - 1);
        if (byte_ready) i++;
      end
    end
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    got = i;
  endtask

  task automatic wait_done(input int budget, output int done_cyc, output int hold_cyc, output bit timeout);
    int c;
    c = 0; hold_cyc = 0;
    while (!done && c < budget) begin
      if (sel_cpu && cpu_reset) hold_cyc++;
      @(negedge clk);
      c++;
    end
    timeout = !done;
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    int w0;
    reset_n = 1'b0; byte_valid = 1'b1; byte_data = 8'hA5; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, mem_we, sel_cpu, cpu_reset, busy, done, error, truncated} !== 8'b0001_0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 00010000",
        {byte_ready, mem_we, sel_cpu, cpu_reset, busy, done, error, truncated});
    end
    checks++;
    if (mem_addr !== BASE || mem_wd !== 32'h0 || mem_write_size !== 2'd0) begin
      errors++; $display("FAIL reset_mem_port: got addr %h wd %h ws %0d expected %h 0 0",
        mem_addr, mem_wd, mem_write_size, BASE);
    end
    checks++;
    if (byte_count !== 32'h0 || error_addr !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got count %0d err_addr %h expected 0 0", byte_count, error_addr);
    end
    w0 = wr_count;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0 || wr_count - w0 != 0) begin
      errors++; $display("FAIL idle_ignores_valid: got ready %b busy %b writes %0d expected 0 0 0",
        byte_ready, busy, wr_count - w0);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    int got, sc, gw, gi, dc, hc, w0, o0, bad; bit to;
    sdata[0] = 8'h13; sdata[1] = 8'h37; sdata[2] = 8'hBE; sdata[3] = 8'hEF;
    w0 = wr_count; o0 = oob;
    run_stream(4, 1'b1, -1, 0, 0, 50, got, sc, gw, gi);
    wait_done(50, dc, hc, to);
    checks++;
    if (to || dc - sc - 1 != 8 + HOLD) begin
      errors++; $display("FAIL basic_done_latency: got %0d cycles (timeout %b) expected %0d", dc - sc - 1, to, 8 + HOLD);
    end
    checks++;
    if (byte_count !== 32'd4 || truncated !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL basic_status: got count %0d trunc %b done %b expected 4 0 1", byte_count, truncated, done);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[i] !== sdata[i]) bad++;
    checks++;
    if (bad != 0 || wr_count - w0 != 4 || oob != o0) begin
      errors++; $display("FAIL basic_contents: got %0d bad bytes %0d writes %0d oob expected 0 4 0", bad, wr_count - w0, oob - o0);
    end
    checks++;
    if (sel_cpu !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0 || bad_wr != 0) begin
      errors++; $display("FAIL basic_run_port: got sel %b rst %b busy %b badwr %0d expected 1 0 0 0", sel_cpu, cpu_reset, busy, bad_wr);
    end
  endtask

  task automatic test_gap();
    int got, sc, gw, gi, dc, hc, w0, bad; bit to;
    for (int i = 0; i < 6; i++) sdata[i] = 8'(8'h40 + 8'(i * 9));
    w0 = wr_count;
    run_stream(6, 1'b1, 3, 5, 0, 60, got, sc, gw, gi);
    wait_done(50, dc, hc, to);
    checks++;
    if (gw != 0 || gi != 0) begin
      errors++; $display("FAIL gap_behaviour: got %0d writes and %0d non-load cycles in gap expected 0 0", gw, gi);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) if (mem[i] !== sdata[i]) bad++;
    checks++;
    if (to || bad != 0 || byte_count !== 32'd6 || wr_count - w0 != 6) begin
      errors++; $display("FAIL gap_contents: got bad %0d count %0d writes %0d timeout %b expected 0 6 6 0",
        bad, byte_count, wr_count - w0, to);
    end
  endtask

  task automatic test_error();
    int got, sc, gw, gi, w0;
    sdata[0] = 8'h11; sdata[1] = 8'h22; sdata[2] = 8'h33;
    sdata[3] = 8'h5A; sdata[4] = 8'h66; sdata[5] = 8'h77;
    force_idx = 13'd3; force_en = 1'b1;
    w0 = wr_count;
    run_stream(6, 1'b1, -1, 0, 0, 40, got, sc, gw, gi);
    checks++;
    if (error !== 1'b1 || error_addr !== 32'h8000_0003) begin
      errors++; $display("FAIL error_flag: got error %b addr %h expected 1 80000003", error, error_addr);
    end
    checks++;
    if (byte_count !== 32'd3 || cpu_reset !== 1'b1 || sel_cpu !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL error_state: got count %0d rst %b sel %b done %b busy %b expected 3 1 0 0 0",
        byte_count, cpu_reset, sel_cpu, done, busy);
    end
    checks++;
    if (got != 4 || wr_count - w0 != 4 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL error_no_consume: got %0d accepted %0d writes ready %b expected 4 4 0", got, wr_count - w0, byte_ready);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got, sc, gw, gi, dc, hc, w0; bit to;
    sdata[0] = 8'h01; sdata[1] = 8'h02; sdata[2] = 8'h03;
    run_stream(3, 1'b0, -1, 0, 0, 40, got, sc, gw, gi);
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b0 || byte_count !== 32'd2) begin
      errors++; $display("FAIL mid_precheck: got busy %b ready %b count %0d expected 1 0 2", busy, byte_ready, byte_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || byte_count !== 32'd0 || mem_addr !== BASE || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL mid_async_reset: got busy %b count %0d addr %h rst %b expected 0 0 %h 1",
        busy, byte_count, mem_addr, cpu_reset, BASE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sdata[0] = 8'hC1; sdata[1] = 8'hC2; sdata[2] = 8'hC3;
    w0 = wr_count;
    run_stream(3, 1'b1, -1, 0, 0, 40, got, sc, gw, gi);
    wait_done(50, dc, hc, to);
    checks++;
    if (to || byte_count !== 32'd3 || mem[0] !== 8'hC1 || mem[1] !== 8'hC2 || mem[2] !== 8'hC3 || wr_count - w0 != 3) begin
      errors++; $display("FAIL mid_restart: got count %0d mem %h %h %h writes %0d expected 3 c1 c2 c3 3",
        byte_count, mem[0], mem[1], mem[2], wr_count - w0);
    end
  endtask

  task automatic test_start_ignored();
    int got, sc, gw, gi, dc, hc; bit to;
    sdata[0] = 8'hA0; sdata[1] = 8'hB1; sdata[2] = 8'hC2; sdata[3] = 8'hD3;
    run_stream(4, 1'b1, -1, 0, 4, 50, got, sc, gw, gi);
    wait_done(50, dc, hc, to);
    checks++;
    if (hc != HOLD) begin
      errors++; $display("FAIL hold_cycles: got %0d expected %0d", hc, HOLD);
    end
    checks++;
    if (to || byte_count !== 32'd4 || mem[0] !== 8'hA0 || mem[3] !== 8'hD3 || dc - sc - 1 != 8 + HOLD) begin
      errors++; $display("FAIL start_in_load: got count %0d mem0 %h mem3 %h latency %0d expected 4 a0 d3 %0d",
        byte_count, mem[0], mem[3], dc - sc - 1, 8 + HOLD);
    end
  endtask

  task automatic test_truncate();
    int got, sc, gw, gi, dc, hc, w0, bad; bit to;
    for (int i = 0; i < 8200; i++) sdata[i] = 8'(i * 7 + 3);
    w0 = wr_count;
    run_stream(8200, 1'b0, -1, 0, 0, 20000, got, sc, gw, gi);
    wait_done(50, dc, hc, to);
    checks++;
    if (got != MSIZE || wr_count - w0 != MSIZE || byte_count !== 32'(MSIZE)) begin
      errors++; $display("FAIL trunc_count: got accepted %0d writes %0d count %0d expected %0d",
        got, wr_count - w0, byte_count, MSIZE);
    end
    checks++;
    if (to || truncated !== 1'b1 || done !== 1'b1 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL trunc_flags: got trunc %b done %b ready %b expected 1 1 0", truncated, done, byte_ready);
    end
    bad = 0;
    for (int i = 0; i < MSIZE; i++) if (mem[i] !== sdata[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL trunc_contents: got %0d bad bytes expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_basic();
    do_reset();
    test_gap();
    do_reset();
    test_error();
    do_reset();
    test_reset_mid();
    do_reset();
    test_start_ignored();
    do_reset();
    test_truncate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
